signed_left_shift_saturating_pipelined: RTL and testbench



---
 rtl/arith_shift_pkg.sv | 15 +
 rtl/signed_left_shift_stage.sv | 91 +++++++++
 rtl/signed_left_shift_saturating_pipelined.sv | 79 +++++++
 tb/tb_signed_left_shift_saturating_pipelined.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_shift_pkg.sv
// Shared definitions for the power-of-two shift datapath blocks.
package arith_shift_pkg;

  localparam int ARITH_SHIFT_W_DEFAULT = 8;
  localparam int ARITH_SHIFT_MAX_W     = 64;

  // Saturation limit for a w-bit signed result: most negative when sign=1,
  // most positive otherwise. Callers narrow the result to their own width.
  function automatic logic [ARITH_SHIFT_MAX_W-1:0] sat_limit(input logic sign, input int w);
    logic [ARITH_SHIFT_MAX_W-1:0] msb_only;
    msb_only = ARITH_SHIFT_MAX_W'(1) << (w - 1);
    return sign ? msb_only : (msb_only - ARITH_SHIFT_MAX_W'(1));
  endfunction

endpackage

// File: rtl/signed_left_shift_stage.sv
// One barrel stage: conditional left shift by 2^K with overflow detection,
// followed by a pipeline register with valid/ready flow control.
module signed_left_shift_stage
  import arith_shift_pkg::*;
#(
  parameter int W  = ARITH_SHIFT_W_DEFAULT,
  parameter int SW = $clog2(W),
  parameter int K  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [W-1:0]  in_value_i,
  input  logic [SW-1:0] in_s_i,
  input  logic          in_ovf_i,
  input  logic          in_sign_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [W-1:0]  out_value_o,
  output logic [SW-1:0] out_s_o,
  output logic          out_ovf_o,
  output logic          out_sign_o
);

  localparam int SH = 1 << K;

  logic          valid_q, valid_d;
  logic [W-1:0]  value_q, value_d;
  logic [SW-1:0] s_q, s_d;
  logic          ovf_q, ovf_d;
  logic          sign_q, sign_d;

  logic [SH:0]   top_bits;
  logic          shift_en;
  logic          stage_ovf;
  logic [W-1:0]  shifted;
  logic          load;

  // Bits that leave the word, plus the new sign bit, must all match the old sign.
  assign top_bits  = in_value_i[W-1 -: SH+1];
  assign shift_en  = in_s_i[K];
  assign stage_ovf = shift_en && !((top_bits == '0) || (top_bits == '1));
  assign shifted   = shift_en ? (in_value_i << SH) : in_value_i;

  // Accept when empty or when the current occupant moves on this cycle.
  assign in_ready_o = !valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o;

  // Next-state: capture a new beat, drain the current one, or hold.
  always_comb begin
    valid_d = valid_q;
    value_d = value_q;
    s_d     = s_q;
    ovf_d   = ovf_q;
    sign_d  = sign_q;
    if (load) begin
      valid_d = 1'b1;
      value_d = shifted;
      s_d     = in_s_i;
      ovf_d   = in_ovf_i || stage_ovf;
      sign_d  = in_sign_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      value_q <= '0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      value_q <= value_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
      sign_q  <= sign_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_value_o = value_q;
  assign out_s_o     = s_q;
  assign out_ovf_o   = ovf_q;
  assign out_sign_o  = sign_q;

endmodule

// File: rtl/signed_left_shift_saturating_pipelined.sv
// Pipelined signed multiply by 2^s: one registered barrel stage per shift bit,
// sticky overflow flag, optional saturation applied after the last stage.
module signed_left_shift_saturating_pipelined
  import arith_shift_pkg::*;
#(
  parameter int W   = ARITH_SHIFT_W_DEFAULT,
  parameter int SW  = $clog2(W),
  parameter bit SAT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [W-1:0]  up_a,
  input  logic [SW-1:0] up_s,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [W-1:0]  down_res,
  output logic          down_ovf
);

  localparam logic [W-1:0] SAT_POS = W'(sat_limit(1'b0, W));
  localparam logic [W-1:0] SAT_NEG = W'(sat_limit(1'b1, W));

  // Index k is the input side of stage k; index SW is the pipe output.
  logic          valid_c [SW+1];
  logic          ready_c [SW+1];
  logic [W-1:0]  value_c [SW+1];
  logic [SW-1:0] s_c     [SW+1];
  logic          ovf_c   [SW+1];
  logic          sign_c  [SW+1];

  // The shift amount is only consumed inside the stages.
  logic unused_tail;

  assign valid_c[0]  = up_valid;
  assign value_c[0]  = up_a;
  assign s_c[0]      = up_s;
  assign ovf_c[0]    = 1'b0;
  assign sign_c[0]   = up_a[W-1];
  assign up_ready    = ready_c[0];
  assign ready_c[SW] = down_ready;
  assign unused_tail = ^s_c[SW];

  for (genvar k = 0; k < SW; k++) begin : g_stage
    signed_left_shift_stage #(
      .W  (W),
      .SW (SW),
      .K  (k)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (valid_c[k]),
      .in_ready_o  (ready_c[k]),
      .in_value_i  (value_c[k]),
      .in_s_i      (s_c[k]),
      .in_ovf_i    (ovf_c[k]),
      .in_sign_i   (sign_c[k]),
      .out_valid_o (valid_c[k+1]),
      .out_ready_i (ready_c[k+1]),
      .out_value_o (value_c[k+1]),
      .out_s_o     (s_c[k+1]),
      .out_ovf_o   (ovf_c[k+1]),
      .out_sign_o  (sign_c[k+1])
    );
  end

  // Output select: clamp to the signed limit on overflow when saturating.
  always_comb begin
    down_res = value_c[SW];
    if (SAT && ovf_c[SW]) begin
      down_res = sign_c[SW] ? SAT_NEG : SAT_POS;
    end
  end

  assign down_valid = valid_c[SW];
  assign down_ovf   = ovf_c[SW];

endmodule

// File: tb/tb_signed_left_shift_saturating_pipelined.sv
// Scoreboard bench: a saturating and a wrapping instance share stimulus; the
// expected results come from plain integer arithmetic a * 2^s.
module tb_signed_left_shift_saturating_pipelined;

  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_valid;
  logic [W-1:0]  up_a;
  logic [SW-1:0] up_s;
  logic          down_ready;
  logic          up_ready, down_valid, down_ovf;
  logic [W-1:0]  down_res;
  logic          up_ready_w, down_valid_w, down_ovf_w;
  logic [W-1:0]  down_res_w;

  always #5 clk = ~clk;

  signed_left_shift_saturating_pipelined #(.W(W), .SW(SW), .SAT(1'b1)) dut (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready),
    .up_a(up_a), .up_s(up_s), .down_valid(down_valid), .down_ready(down_ready),
    .down_res(down_res), .down_ovf(down_ovf)
  );

  signed_left_shift_saturating_pipelined #(.W(W), .SW(SW), .SAT(1'b0)) dut_w (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready_w),
    .up_a(up_a), .up_s(up_s), .down_valid(down_valid_w), .down_ready(down_ready),
    .down_res(down_res_w), .down_ovf(down_ovf_w)
  );

  typedef struct packed {
    logic [7:0] sat;
    logic [7:0] wrap;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n_in  = 0;
  int   n_out = 0;
  logic rnd_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact product, then range check, wrap and clamp.
  function automatic exp_t model(input logic [7:0] a, input logic [2:0] s);
    int   p;
    exp_t e;
    p      = int'($signed(a)) * (1 << s);
    e.ovf  = (p > 127) || (p < -128);
    e.wrap = p[7:0];
    e.sat  = e.ovf ? ((p < 0) ? 8'h80 : 8'h7F) : p[7:0];
    return e;
  endfunction

  task automatic send(input logic [7:0] a, input logic [2:0] s);
    int waited = 0;
    up_valid = 1'b1;
    up_a     = a;
    up_s     = s;
    while (1) begin
      @(negedge clk);
      if (up_ready) begin
        sb.push_back(model(a, s));
        n_in++;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waited++;
      if (waited > 1000) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    up_valid = 1'b0;
  endtask

  task automatic drain();
    down_ready = 1'b1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops expectations on each output handshake and checks stall stability.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_res;
    logic       prev_ovf;
    exp_t       e;
    prev_stall = 1'b0;
    prev_res   = '0;
    prev_ovf   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      if (down_valid_w !== down_valid) chk("valid_match", 32'(down_valid_w), 32'(down_valid));
      if (prev_stall) begin
        chk("hold_valid", 32'(down_valid), 32'd1);
        chk("hold_res", 32'(down_res), 32'(prev_res));
        chk("hold_ovf", 32'(down_ovf), 32'(prev_ovf));
      end
      if (down_valid && down_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          n_out++;
          chk("res_sat", 32'(down_res), 32'(e.sat));
          chk("res_wrap", 32'(down_res_w), 32'(e.wrap));
          chk("ovf_sat", 32'(down_ovf), 32'(e.ovf));
          chk("ovf_wrap", 32'(down_ovf_w), 32'(e.ovf));
        end
      end
      prev_stall = down_valid && !down_ready;
      prev_res   = down_res;
      prev_ovf   = down_ovf;
    end
  end

  // Random backpressure while the random phase runs.
  initial begin
    wait (rnd_on);
    while (rnd_on) begin
      @(posedge clk); #1;
      down_ready = ($urandom_range(0, 99) < 70);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] da [11];
    logic [2:0] ds [11];
    logic [7:0] edge_vals [5];
    int         lat;
    logic       stale;
    logic [7:0] ra;

    da = '{8'd5, 8'hFD, 8'hF0, 8'd20, 8'hEF, 8'h80, 8'h00, 8'h7F, 8'h80, 8'hC0, 8'hFF};
    ds = '{3'd3, 3'd2, 3'd3, 3'd3, 3'd3, 3'd1, 3'd7, 3'd0, 3'd0, 3'd1, 3'd7};
    edge_vals = '{8'h00, 8'h80, 8'h7F, 8'hFF, 8'h01};

    rst        = 1'b1;
    up_valid   = 1'b0;
    up_a       = '0;
    up_s       = '0;
    down_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_down_valid", 32'(down_valid), 32'd0);
    chk("rst_down_res", 32'(down_res), 32'd0);
    chk("rst_down_ovf", 32'(down_ovf), 32'd0);
    chk("rst_up_ready", 32'(up_ready), 32'd1);
    @(posedge clk); #1;

    // Latency: 5 <<< 3 appears three edges after acceptance.
    up_valid = 1'b1;
    up_a     = 8'd5;
    up_s     = 3'd3;
    @(negedge clk);
    chk("lat_up_ready", 32'(up_ready), 32'd1);
    sb.push_back(model(8'd5, 3'd3));
    n_in++;
    @(posedge clk); #1;
    up_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (down_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    @(posedge clk); #1;

    // Directed values, including the exact and overflowing boundaries.
    for (int i = 0; i < 11; i++) send(da[i], ds[i]);
    drain();

    // Backpressure: three beats fill the pipe, then release.
    down_ready = 1'b0;
    send(8'd1, 3'd1);
    send(8'd2, 3'd2);
    send(8'd3, 3'd3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_up_ready", 32'(up_ready), 32'd0);
    chk("bp_down_valid", 32'(down_valid), 32'd1);
    chk("bp_head", 32'(down_res), 32'd2);
    @(posedge clk); #1;
    down_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_burst_valid", 32'(down_valid), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bp_after_empty", 32'(down_valid), 32'd0);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // Reset with two beats in flight: nothing may emerge afterwards.
    send(8'd7, 3'd1);
    send(8'd9, 3'd2);
    rst = 1'b1;
    sb.delete();
    n_in  = 0;
    n_out = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_down_valid", 32'(down_valid), 32'd0);
    chk("midrst_up_ready", 32'(up_ready), 32'd1);
    chk("midrst_down_res", 32'(down_res), 32'd0);
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (down_valid) stale = 1'b1;
    end
    chk("midrst_no_stale", 32'(stale), 32'd0);
    @(posedge clk); #1;

    // Random traffic with random backpressure and occasional idle cycles.
    rnd_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      if ($urandom_range(0, 7) == 0) ra = edge_vals[$urandom_range(0, 4)];
      else                           ra = 8'($urandom);
      send(ra, 3'($urandom_range(0, 7)));
    end
    rnd_on = 1'b0;
    @(posedge clk); #2;
    drain();
    chk("count_in_out", 32'(n_out), 32'(n_in));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
